// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready in and out.
// Define DIV_SIGNED_EN to honour signed_op; otherwise every operation is unsigned.
module div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH+1:0] p_shift, diff;

  assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign sign_a   = signed_op & dividend[WIDTH-1];
  assign sign_b   = signed_op & divisor[WIDTH-1];
  assign a_mag    = sign_a ? -dividend : dividend;
  assign b_mag    = sign_b ? -divisor : divisor;
  assign quot_fix = neg_quot_q ? -a_q : a_q;
  assign rem_fix  = neg_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign quot_fix = a_q;
  assign rem_fix  = p_q[WIDTH-1:0];
`endif

  // Trial subtraction on the shifted partial remainder; MSB set means it went negative.
  assign p_shift = {p_q, a_q[WIDTH-1]};
  assign diff    = p_shift - {2'b00, b_q};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_valid) state_d = div_zero ? StDone : StCalc;
      StCalc:  if (count_q == CNT_W'(1)) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_ready = (state_q == StIdle);
    out_valid   = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          dbz_d = div_zero;
          if (div_zero) begin
            quot_d = '1;
            rem_d  = dividend;
          end else begin
            p_d     = '0;
            a_d     = a_mag;
            b_d     = b_mag;
            count_d = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
            neg_quot_d = sign_a ^ sign_b;
            neg_rem_d  = sign_a;
`endif
          end
        end
      end
      StCalc: begin
        count_d = count_q - CNT_W'(1);
        if (!diff[WIDTH+1]) begin
          p_d = diff[WIDTH:0];
          a_d = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          p_d = p_shift[WIDTH:0];
          a_d = {a_q[WIDTH-2:0], 1'b0};
        end
      end
      StFixup: begin
        quot_d = quot_fix;
        rem_d  = rem_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq at WIDTH=32: expected results queued at accept, checked at out_valid.
module tb_div_seq;
  localparam int W = 32;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int unsigned  lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t   m;
    longint sa, sb, sq, sr;
    m.lat = W + 2;
    m.dbz = 1'b0;
    if (b == '0) begin
      m.q   = '1;
      m.r   = a;
      m.dbz = 1'b1;
      m.lat = 1;
    end else if (SignedEn && sgn) begin
      sa  = $signed(a);
      sb  = $signed(b);
      sq  = sa / sb;
      sr  = sa % sb;
      m.q = sq[W-1:0];
      m.r = sr[W-1:0];
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    return m;
  endfunction

  // Call at posedge+1 with the DUT idle; bp = cycles of held-off out_ready after out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input int bp);
    exp_t        e;
    int unsigned lat;
    check("idle_start_ready", start_ready, 1);
    start_valid = 1'b1;
    dividend    = a;
    divisor     = b;
    signed_op   = sgn;
    out_ready   = 1'b0;
    sb_q.push_back(model(a, b, sgn));
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = $urandom;
    divisor     = $urandom;
    signed_op   = 1'($urandom_range(1));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", div_by_zero, e.dbz);
    for (int i = 0; i < bp; i++) begin
      if (i == 3) begin
        start_valid = 1'b1;
        dividend    = 32'd77;
        divisor     = 32'd7;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      check("bp_valid", out_valid, 1);
      check("bp_start_ready", start_ready, 0);
      check("bp_quotient", quotient, e.q);
      check("bp_remainder", remainder, e.r);
      check("bp_dbz", div_by_zero, e.dbz);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_start_ready", start_ready, 1);
    check("hold_quotient", quotient, e.q);
    check("hold_dbz", div_by_zero, e.dbz);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'd9, 32'd3, 1'b0, 0);
    run_op(-32'd7, 32'd2, 1'b1, 0);
    run_op(32'd7, -32'd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'd3, 32'd10, 1'b0, 0);
    run_op(32'd1234567, 32'd89, 1'b0, 10);
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(1)), 0);
    end

    // Abort an operation mid-CALC; nothing goes on the scoreboard for it.
    start_valid = 1'b1;
    dividend    = 32'd1000;
    divisor     = 32'd3;
    signed_op   = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_start_ready", start_ready, 1);
    check("midrst_quotient", quotient, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_valid", out_valid, 0);
    run_op(32'd1000, 32'd3, 1'b0, 0);

    check("sb_empty", 64'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
